// File: rtl/uk101_loader_pkg.sv
// Shared definitions for the UK101 ASCII serial loader.
//   load_state_t : transmitter FSM states
//   ASCII_CR/LF  : line-ending characters that drive translation and the line gap
//   baud_div()   : rounded clock-cycles-per-bit, 18 bits wide
package uk101_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } load_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Round-to-nearest integer division; 50 MHz / 300 baud still fits in 18 bits.
  function automatic logic [17:0] baud_div(input int clk_hz, input int baud);
    int q;
    q = (clk_hz + baud / 2) / baud;
    return q[17:0];
  endfunction

endpackage

// File: rtl/ascii_serial_loader_baud_tick_gen.sv
// Bit-time timer for the serial loader.
//   clk, n_reset : system clock, asynchronous active-low reset
//   load         : latch div and restart the count at div-1
//   run          : count down while high; reloads from the latched div at 0
//   div          : clock cycles per bit (18 bits)
//   tick         : high during the last cycle of each bit time
module baud_tick_gen (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        load,
  input  logic        run,
  input  logic [17:0] div,
  output logic        tick
);

  logic [17:0] div_reg;
  logic [17:0] count_reg;

  // div is latched on load so a baud change mid-frame cannot alter bit width.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_reg   <= '0;
      count_reg <= '0;
    end else if (load) begin
      div_reg   <= div;
      count_reg <= div - 18'd1;
    end else if (run) begin
      if (count_reg == '0) count_reg <= div_reg - 18'd1;
      else                 count_reg <= count_reg - 18'd1;
    end
  end

  assign tick = run & ~load & (count_reg == '0);

endmodule

// File: rtl/ascii_serial_loader.sv
// Streams downloaded ASCII file bytes out as 8N1 serial into the UK101 ACIA.
//   clk, n_reset    : system clock, asynchronous active-low reset
//   enable          : file loading selected
//   baud_rate       : 0 = BAUD_FAST, 1 = BAUD_SLOW (sampled at frame start)
//   ioctl_download  : download in progress; rising edge forgets a pending CR
//   ioctl_wr        : one-cycle strobe qualifying ioctl_dout
//   ioctl_dout      : file byte
//   ioctl_wait      : back-pressure, high from capture until the frame/gap ends
//   txd             : serial output, idle high
//   busy            : high in any state other than IDLE
// A CR is followed by LINE_GAP_BITS idle bit-times so BASIC can tokenise
// the line; LF after CR is swallowed, a lone LF becomes CR.
module ascii_serial_loader
  import uk101_loader_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int BAUD_FAST     = 9600,
  parameter int BAUD_SLOW     = 300,
  parameter int LINE_GAP_BITS = 40
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       enable,
  input  logic       baud_rate,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  output logic       txd,
  output logic       busy
);

  localparam logic [17:0] DIV_FAST = baud_div(CLK_HZ, BAUD_FAST);
  localparam logic [17:0] DIV_SLOW = baud_div(CLK_HZ, BAUD_SLOW);
  localparam bit          HAS_GAP  = (LINE_GAP_BITS > 0);
  localparam int          GAP_W    = (LINE_GAP_BITS > 1) ? $clog2(LINE_GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((LINE_GAP_BITS > 0) ? (LINE_GAP_BITS - 1) : 0);

  load_state_t      state_reg, state_next;
  logic [7:0]       shift_reg, shift_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             is_cr_reg, is_cr_next;
  logic             txd_reg, txd_next;
  logic             wait_reg, wait_next;
  logic             last_was_cr_reg, last_was_cr_next;
  logic             dl_prev_reg;

  logic             dl_rise;
  logic             accept;
  logic [7:0]       byte7;
  logic             is_lf;
  logic             drop;
  logic [7:0]       tx_byte;
  logic [17:0]      div_sel;
  logic             tick;

  assign dl_rise = ioctl_download & ~dl_prev_reg;
  assign accept  = ioctl_wr & ioctl_download & enable & ~wait_reg;
  assign byte7   = ioctl_dout & 8'h7F;
  assign is_lf   = (byte7 == ASCII_LF);
  // A download that starts on this very cycle must not see the previous file's CR.
  assign drop    = is_lf & last_was_cr_reg & ~dl_rise;
  assign tx_byte = is_lf ? ASCII_CR : byte7;
  assign div_sel = baud_rate ? DIV_SLOW : DIV_FAST;

  baud_tick_gen u_tick (
    .clk     (clk),
    .n_reset (n_reset),
    .load    (accept & ~drop),
    .run     (state_reg != IDLE),
    .div     (div_sel),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      is_cr_reg       <= 1'b0;
      txd_reg         <= 1'b1;
      wait_reg        <= 1'b0;
      last_was_cr_reg <= 1'b0;
      dl_prev_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      bit_cnt_reg     <= bit_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      is_cr_reg       <= is_cr_next;
      txd_reg         <= txd_next;
      wait_reg        <= wait_next;
      last_was_cr_reg <= last_was_cr_next;
      dl_prev_reg     <= ioctl_download;
    end
  end

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    bit_cnt_next     = bit_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    is_cr_next       = is_cr_reg;
    txd_next         = txd_reg;
    wait_next        = wait_reg;
    last_was_cr_next = last_was_cr_reg;

    if (dl_rise) last_was_cr_next = 1'b0;
    if (accept)  last_was_cr_next = (byte7 == ASCII_CR);

    case (state_reg)
      IDLE: begin
        // Only a dropped LF leaves wait high in IDLE; release it one cycle on.
        if (wait_reg) wait_next = 1'b0;
        if (accept) begin
          wait_next = 1'b1;
          if (!drop) begin
            state_next   = START;
            txd_next     = 1'b0;
            shift_next   = tx_byte;
            is_cr_next   = (tx_byte == ASCII_CR);
            bit_cnt_next = '0;
          end
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          txd_next   = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_reg == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            txd_next     = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (is_cr_reg && HAS_GAP) begin
            state_next   = GAP;
            gap_cnt_next = GAP_LOAD;
          end else begin
            state_next = IDLE;
            wait_next  = 1'b0;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_reg == '0) begin
            state_next = IDLE;
            wait_next  = 1'b0;
          end else begin
            gap_cnt_next = gap_cnt_reg - GAP_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
        wait_next  = 1'b0;
      end
    endcase
  end

  assign ioctl_wait = wait_reg;
  assign txd        = txd_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ascii_serial_loader.sv
module tb_ascii_serial_loader;

  localparam int CLK_HZ = 1000;
  localparam int BF     = 100;
  localparam int BS     = 30;
  localparam int LG     = 4;
  // Bit periods from round(CLK_HZ / baud): 10 and 33 cycles.
  localparam int DIV_F  = $rtoi(real'(CLK_HZ) / real'(BF) + 0.5);
  localparam int DIV_S  = $rtoi(real'(CLK_HZ) / real'(BS) + 0.5);

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       enable = 1'b1;
  logic       baud_rate = 1'b0;
  logic       ioctl_download = 1'b1;
  logic       ioctl_wr = 1'b0;
  logic [7:0] ioctl_dout = 8'h00;
  logic       ioctl_wait;
  logic       txd;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_lwc = 1'b0;

  ascii_serial_loader #(
    .CLK_HZ(CLK_HZ), .BAUD_FAST(BF), .BAUD_SLOW(BS), .LINE_GAP_BITS(LG)
  ) dut (
    .clk(clk), .n_reset(n_reset), .enable(enable), .baud_rate(baud_rate),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    bit         slow;
    bit         new_dl;
    logic [7:0] sent;
    bit         drop;
    bit         cr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one write strobe; returns #1 after the capturing edge (frame time t=0).
  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(posedge clk);
    #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic new_download();
    @(negedge clk);
    ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    model_lwc = 1'b0;
  endtask

  // Reference translation: bit7 stripped, LF after CR swallowed, lone LF -> CR.
  function automatic void model_byte(input logic [7:0] din, output bit drop,
                                     output logic [7:0] sent, output bit cr);
    logic [7:0] b;
    b    = din & 8'h7F;
    drop = 1'b0;
    sent = b;
    if (b == 8'h0A) begin
      drop = model_lwc;
      sent = 8'h0D;
    end
    cr        = !drop && (sent == 8'h0D);
    model_lwc = (b == 8'h0D);
  endfunction

  // Expect one 8N1 frame of 'sent' (plus LG idle bit-times if cr), starting at t=0.
  task automatic run_frame(input string tag, input logic [7:0] sent, input int div, input bit cr);
    int total;
    total = (cr ? (10 + LG) : 10) * div;
    for (int t = 0; t < total; t++) begin
      int k;
      int ph;
      logic exp_bit;
      k  = t / div;
      ph = t % div;
      if (t < 10 * div) begin
        if (ph == 0 || ph == div - 1) begin
          if (k == 0)      exp_bit = 1'b0;
          else if (k <= 8) exp_bit = sent[k-1];
          else             exp_bit = 1'b1;
          check({tag, "_txd"}, 32'(txd), 32'(exp_bit));
        end
      end else if (ph == 0) begin
        check({tag, "_gap_txd"}, 32'(txd), 32'd1);
      end
      if (t == 0 || t == total - 1) begin
        check({tag, "_wait_hi"}, 32'(ioctl_wait), 32'd1);
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
      end
      step();
    end
    check({tag, "_wait_end"}, 32'(ioctl_wait), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_txd_end"}, 32'(txd), 32'd1);
    $display("frame %s byte=%02h div=%0d cr=%0d done", tag, sent, div, cr);
  endtask

  task automatic check_drop(input string tag);
    check({tag, "_drop_wait"}, 32'(ioctl_wait), 32'd1);
    check({tag, "_drop_busy"}, 32'(busy), 32'd0);
    check({tag, "_drop_txd"}, 32'(txd), 32'd1);
    step();
    check({tag, "_drop_wait_clr"}, 32'(ioctl_wait), 32'd0);
    $display("drop %s done", tag);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (i == 0 || i == cycles - 1) begin
        check({tag, "_q_txd"}, 32'(txd), 32'd1);
        check({tag, "_q_busy"}, 32'(busy), 32'd0);
        check({tag, "_q_wait"}, 32'(ioctl_wait), 32'd0);
      end
      step();
    end
    $display("quiet %s done", tag);
  endtask

  initial begin
    vecs[0] = '{8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[2] = '{8'h0D, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b1};
    vecs[3] = '{8'h0A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h0A, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b1};
    vecs[5] = '{8'hC1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[6] = '{8'h8D, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b1};
    vecs[7] = '{8'h8A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h0A, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b1};
    vecs[9] = '{8'hFF, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    check("post_rst_txd", 32'(txd), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].new_dl) new_download();
      @(negedge clk);
      baud_rate = vecs[i].slow;
      write_byte(vecs[i].din);
      if (vecs[i].drop) check_drop($sformatf("vec%0d", i));
      else run_frame($sformatf("vec%0d", i), vecs[i].sent, vecs[i].slow ? DIV_S : DIV_F, vecs[i].cr);
    end
    @(negedge clk);
    baud_rate = 1'b0;

    // Baud toggled mid-frame must not change bit width
    @(negedge clk);
    baud_rate = 1'b1;
    write_byte(8'h33);
    fork
      run_frame("slow_toggle", 8'h33, DIV_S, 1'b0);
      begin
        repeat (50) @(negedge clk);
        baud_rate = 1'b0;
        repeat (100) @(negedge clk);
        baud_rate = 1'b1;
      end
    join
    @(negedge clk);
    baud_rate = 1'b0;

    // Writes while wait high, and with enable low, are ignored
    write_byte(8'h41);
    fork
      run_frame("busy_wr", 8'h41, DIV_F, 1'b0);
      begin
        repeat (15) @(negedge clk);
        ioctl_dout = 8'h7E;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        repeat (25) @(negedge clk);
        enable     = 1'b0;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        repeat (10) @(negedge clk);
        enable     = 1'b1;
      end
    join
    check_quiet("after_busy_wr", 2 * DIV_F);

    @(negedge clk);
    enable = 1'b0;
    write_byte(8'h42);
    check("en0_wait", 32'(ioctl_wait), 32'd0);
    check("en0_busy", 32'(busy), 32'd0);
    check_quiet("en0", 2 * DIV_F);
    @(negedge clk);
    enable = 1'b1;

    // enable and download fall mid-frame: CR frame and gap still complete
    write_byte(8'h0D);
    fork
      run_frame("dl_fall", 8'h0D, DIV_F, 1'b1);
      begin
        repeat (30) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        ioctl_download = 1'b0;
      end
    join
    write_byte(8'h43);
    check("dl0_wait", 32'(ioctl_wait), 32'd0);
    check("dl0_busy", 32'(busy), 32'd0);
    check_quiet("dl0", 2 * DIV_F);
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    model_lwc = 1'b0;

    // Reset during DATA
    write_byte(8'h00);
    repeat (3 * DIV_F) step();
    check("mid_data_txd", 32'(txd), 32'd0);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("async_rst_txd", 32'(txd), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_wait", 32'(ioctl_wait), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    model_lwc = 1'b0;
    write_byte(8'h41);
    run_frame("post_rst", 8'h41, DIV_F, 1'b0);

    // Randomised stream against the reference model
    new_download();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] din;
      logic [7:0] sent;
      bit drop;
      bit cr;
      bit slow;
      int r;
      if (i % 10 == 9) new_download();
      r = $urandom_range(0, 9);
      if (r < 2)      din = ($urandom_range(0, 1) != 0) ? 8'h8D : 8'h0D;
      else if (r < 4) din = ($urandom_range(0, 1) != 0) ? 8'h8A : 8'h0A;
      else            din = 8'($urandom_range(0, 255));
      slow = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      baud_rate = slow;
      model_byte(din, drop, sent, cr);
      write_byte(din);
      if (drop) check_drop($sformatf("rnd%0d", i));
      else run_frame($sformatf("rnd%0d", i), sent, slow ? DIV_S : DIV_F, cr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
